// File: rtl/led_pwm_blink_driver.sv
// led_pwm_blink_driver
//   Takes the 8-bit LED word from the LED controller and drives the 8 board
//   LED pins with a global brightness PWM and per-LED blinking. It has its own
//   register slave using the same bus protocol as the LED controller.
//
// Build option:
//   LED_PWM_FADE_EN  when defined, the effective duty moves one step per PWM
//                    period toward the programmed duty (linear fade). When
//                    undefined, it jumps to the programmed duty at the next
//                    PWM period boundary.
//
// Ports:
//   clk       in   1   clock, all logic on posedge
//   reset     in   1   synchronous, active-high
//   we        in   1   write enable, qualified by cs
//   cs        in   1   chip select
//   reg_sel   in   2   0 DUTY, 1 BLINK_PER, 2 BLINK_MASK, 3 CTRL/STATUS
//   in        in   16  write data
//   out       out 16   read data (combinational), 0 when cs=0
//   led_in    in   8   LED word from the LED controller (1 = LED on)
//   led_pins  out  8   registered LED pin drive
//
// Bus protocol: there is no handshake. A write is the single cycle where
// cs & we are both high; it is accepted unconditionally and its effect is
// visible from the next clock. A read is any cycle with cs high and we low;
// out reflects the selected register in the same cycle. With cs low, we is
// ignored and out is 0.
module led_pwm_blink_driver #(
  parameter int PRESCALE   = 100,
  parameter int BLINK_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        cs,
  input  logic [1:0]  reg_sel,
  input  logic [15:0] in,
  output logic [15:0] out,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_pins
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [7:0]            duty;
  logic [7:0]            duty_eff;
  logic [7:0]            duty_next;
  logic [7:0]            blink_mask;
  logic [7:0]            pwm_cnt;
  logic [BLINK_BITS-1:0] blink_per;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  enable;
  logic                  blink_phase;
  logic [PS_W-1:0]       prescaler;

  logic wr, wr_duty, wr_per, wr_mask, wr_ctrl, restart;
  logic tick, wrap, pwm_on;
  logic [7:0] blink_gate;

  assign wr      = cs & we;
  assign wr_duty = wr & (reg_sel == 2'd0);
  assign wr_per  = wr & (reg_sel == 2'd1);
  assign wr_mask = wr & (reg_sel == 2'd2);
  assign wr_ctrl = wr & (reg_sel == 2'd3);
  // Restart is a strobe carried on the CTRL write; it is never stored.
  assign restart = wr_ctrl & in[1];

  // Counters only advance while enabled, so disabling freezes the pattern.
  assign tick = enable & (prescaler == PS_LAST);
  // A restart in the same cycle cancels the period boundary entirely.
  assign wrap = tick & (pwm_cnt == 8'hFF) & ~restart;

  assign pwm_on = (duty_eff == 8'hFF) | (pwm_cnt < duty_eff);

  // Unmasked LEDs pass through; masked LEDs follow the blink phase.
  assign blink_gate = ~blink_mask | {8{blink_phase}};

  always_comb begin
    duty_next = duty_eff;
`ifdef LED_PWM_FADE_EN
    if (duty_eff < duty) begin
      duty_next = duty_eff + 8'd1;
    end else if (duty_eff > duty) begin
      duty_next = duty_eff - 8'd1;
    end
`else
    duty_next = duty;
`endif
  end

  // Prescaler and PWM step counter.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      prescaler <= '0;
      pwm_cnt   <= 8'h00;
    end else if (tick) begin
      prescaler <= '0;
      pwm_cnt   <= pwm_cnt + 8'd1;
    end else if (enable) begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Blink period register, counter and phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_per   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr_per) begin
      blink_per   <= in[BLINK_BITS-1:0];
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (restart || (blink_per == '0)) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wrap) begin
      if (blink_cnt == blink_per - BLINK_BITS'(1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_BITS'(1);
      end
    end
  end

  // Configuration registers; duty_eff only changes on a period boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty       <= 8'h80;
      duty_eff   <= 8'h80;
      blink_mask <= 8'h00;
      enable     <= 1'b1;
    end else begin
      if (wr_duty) duty       <= in[7:0];
      if (wr_mask) blink_mask <= in[7:0];
      if (wr_ctrl) enable     <= in[0];
      if (wrap)    duty_eff   <= duty_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_pins <= 8'h00;
    end else if (enable && pwm_on) begin
      led_pins <= led_in & blink_gate;
    end else begin
      led_pins <= 8'h00;
    end
  end

  always_comb begin
    out = 16'h0000;
    if (cs) begin
      case (reg_sel)
        2'd0:    out = {8'h00, duty};
        2'd1:    out = 16'(blink_per);
        2'd2:    out = {8'h00, blink_mask};
        default: out = {led_pins, 6'h00, blink_phase, enable};
      endcase
    end
  end

endmodule
